// File: rtl/spi_sensor_emu.sv
// -----------------------------------------------------------------------------
// spi_sensor_emu
//   SPI slave (mode 1: CPOL=0, CPHA=1) that emulates a simple sensor. Every
//   32-bit frame carries a command: CONVERT, CLEAR, WRITE or READ. The response
//   to a command is returned two completed frames later, through a two-stage
//   response pipeline.
//
// Parameters
//   NREG    number of 16-bit config registers (addresses 0..NREG-1, NREG >= 2)
//   ID_VAL  read-only value returned by register NREG-1
//
// Ports
//   sclk         in   SPI clock, idles low; mosi sampled on falling edge,
//                     miso launched on rising edge
//   rst_n        in   asynchronous active-low reset
//   cs_n         in   chip select, active low; high clears the frame state
//   mosi         in   command bit, MSB first
//   miso         out  response bit, MSB first; forced low while cs_n is high
//   frame_count  out  number of completed frames (wraps at 16 bits)
//   last_cmd     out  most recent completed command word
// -----------------------------------------------------------------------------
module spi_sensor_emu #(
   parameter int          NREG   = 8,
   parameter logic [15:0] ID_VAL = 16'h2116
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic [15:0] frame_count,
   output logic [31:0] last_cmd
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   localparam logic [1:0] OP_CONVERT = 2'b00;
   localparam logic [1:0] OP_CLEAR   = 2'b01;
   localparam logic [1:0] OP_WRITE   = 2'b10;
   localparam logic [1:0] OP_READ    = 2'b11;

   // Frame state is wiped by reset or by the master deselecting us.
   logic frame_clr_n;
   assign frame_clr_n = rst_n & ~cs_n;

   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [30:0]   shift_q;
   logic [31:0]   cmd_d;
   logic          frame_done;

   logic [1:0]    opcode;
   logic [3:0]    chan;
   logic [AW-1:0] addr;
   logic [15:0]   data;
   logic [15:0]   rd_val;
   logic [31:0]   resp_d;

   logic [31:0]   stage1_q, stage2_q;
   logic [27:0]   sample_cnt_q;
   logic [15:0]   frame_count_q;
   logic [31:0]   last_cmd_q;
   logic [15:0]   regs_q [NREG-1];
   logic          miso_q;

   always_comb begin
      // Counter saturates at 32 so extra edges in one selection never start a
      // second frame.
      bit_cnt_d  = bit_cnt_q[5] ? bit_cnt_q : bit_cnt_q + 6'd1;
      // The word is complete once the bit arriving on this edge is appended.
      cmd_d      = {shift_q, mosi};
      frame_done = ~cs_n & (bit_cnt_q == 6'd31);

      opcode = cmd_d[31:30];
      chan   = cmd_d[19:16];
      addr   = cmd_d[16 +: AW];
      data   = cmd_d[15:0];

      rd_val = 16'h0000;
      if (addr == AW'(NREG - 1)) begin
         rd_val = ID_VAL;
      end else begin
         for (int i = 0; i < NREG - 1; i++) begin
            if (addr == AW'(i)) rd_val = regs_q[i];
         end
      end

      case (opcode)
         OP_CONVERT: resp_d = {chan, sample_cnt_q};
         OP_CLEAR:   resp_d = 32'h0000_0000;
         OP_WRITE:   resp_d = {16'h0000, data};
         default:    resp_d = {16'h0000, rd_val};
      endcase
   end

   // ---- stage: command shift-in (falling sclk) ----
   always_ff @(negedge sclk or negedge frame_clr_n) begin
      if (!frame_clr_n) begin
         bit_cnt_q <= 6'd0;
         shift_q   <= 31'd0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         if (!bit_cnt_q[5]) shift_q <= cmd_d[30:0];
      end
   end

   // ---- stage: decode, side effects and response pipeline (32nd falling edge) ----
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         stage1_q      <= 32'd0;
         stage2_q      <= 32'd0;
         sample_cnt_q  <= 28'd0;
         frame_count_q <= 16'd0;
         last_cmd_q    <= 32'd0;
         for (int i = 0; i < NREG - 1; i++) regs_q[i] <= 16'h0000;
      end else if (frame_done) begin
         stage2_q      <= stage1_q;
         stage1_q      <= resp_d;
         frame_count_q <= frame_count_q + 16'd1;
         last_cmd_q    <= cmd_d;
         case (opcode)
            OP_CONVERT: sample_cnt_q <= sample_cnt_q + 28'd1;
            OP_CLEAR:   sample_cnt_q <= 28'd0;
            OP_WRITE: begin
               // The top address is the ID register; it has no storage.
               for (int i = 0; i < NREG - 1; i++) begin
                  if (addr == AW'(i)) regs_q[i] <= data;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- stage: response shift-out (rising sclk) ----
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         miso_q <= 1'b0;
      end else if (!cs_n) begin
         // Bit 31-n of the oldest response; ~n[4:0] equals 31-n for n < 32.
         miso_q <= bit_cnt_q[5] ? 1'b0 : stage2_q[~bit_cnt_q[4:0]];
      end
   end

   assign miso        = miso_q & ~cs_n;
   assign frame_count = frame_count_q;
   assign last_cmd    = last_cmd_q;

endmodule

// File: tb/tb_spi_sensor_emu.sv
module tb_spi_sensor_emu;

   logic        sclk;
   logic        rst_n;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [15:0] frame_count;
   logic [31:0] last_cmd;

   int n_total = 0;
   int n_bad   = 0;

   spi_sensor_emu #(.NREG(8), .ID_VAL(16'h2116)) dut (
      .sclk        (sclk),
      .rst_n       (rst_n),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .frame_count (frame_count),
      .last_cmd    (last_cmd)
   );

   // ---------------- reference model ----------------
   logic [15:0] m_reg [0:7];
   logic [27:0] m_scnt;
   logic [15:0] m_fc;
   logic [31:0] m_last;
   logic [31:0] m_hist [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [1:0] op, input logic [3:0] ch,
                                      input logic [15:0] d);
      return {op, 10'h000, ch, d};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_scnt = 28'd0;
      m_fc   = 16'd0;
      m_last = 32'd0;
      m_hist.delete();
   endtask

   // Word the next completed frame will carry: response from two frames back.
   function automatic logic [31:0] m_expect_tx();
      if (m_hist.size() >= 2) return m_hist[m_hist.size() - 2];
      return 32'h0;
   endfunction

   task automatic model_frame(input logic [31:0] cmd);
      logic [31:0] r;
      logic [2:0]  a;
      a = cmd[18:16];
      case (cmd[31:30])
         2'b00: begin r = {cmd[19:16], m_scnt}; m_scnt = m_scnt + 28'd1; end
         2'b01: begin r = 32'h0; m_scnt = 28'd0; end
         2'b10: begin r = {16'h0, cmd[15:0]}; if (a != 3'd7) m_reg[a] = cmd[15:0]; end
         default: r = {16'h0, (a == 3'd7) ? 16'h2116 : m_reg[a]};
      endcase
      m_hist.push_back(r);
      m_fc   = m_fc + 16'd1;
      m_last = cmd;
   endtask

   // ---------------- SPI master ----------------
   task automatic spi_xfer(input logic [31:0] cmd, input int nbits, output logic [31:0] rx);
      rx   = 32'h0;
      cs_n = 1'b0;
      #5;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = (i < 32) ? cmd[31 - i] : 1'($urandom & 1);
         #5;
         if (i < 32) rx[31 - i] = miso;
         if (i == 32) chk("miso past bit 32", {31'b0, miso}, 32'h0);
         sclk = 1'b0;
         #5;
      end
      #2 cs_n = 1'b1;
      #5;
   endtask

   task automatic full_frame(input logic [31:0] cmd, input int nbits, input string tag,
                             output logic [31:0] rx);
      logic [31:0] exp;
      exp = m_expect_tx();
      spi_xfer(cmd, nbits, rx);
      model_frame(cmd);
      chk({tag, " rx"}, rx, exp);
      chk({tag, " frame_count"}, {16'h0, frame_count}, {16'h0, m_fc});
      chk({tag, " last_cmd"}, last_cmd, m_last);
      chk({tag, " miso idle"}, {31'b0, miso}, 32'h0);
   endtask

   task automatic abort_frame(input logic [31:0] cmd, input int nbits, input string tag);
      logic [31:0] rx, exp;
      exp = m_expect_tx();
      spi_xfer(cmd, nbits, rx);
      chk({tag, " partial rx"}, rx >> (32 - nbits), exp >> (32 - nbits));
      chk({tag, " frame_count"}, {16'h0, frame_count}, {16'h0, m_fc});
      chk({tag, " last_cmd"}, last_cmd, m_last);
   endtask

   initial begin
      logic [31:0] rx;
      logic [31:0] c;
      int          sel, nb;

      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #3;
      chk("reset frame_count", {16'h0, frame_count}, 32'h0);
      chk("reset last_cmd", last_cmd, 32'h0);
      chk("reset miso", {31'b0, miso}, 32'h0);
      rst_n = 1'b1;
      #5;

      // Three CONVERT ch3 frames
      full_frame(mk(2'b00, 4'd3, 16'h0), 32, "conv0", rx);
      chk("conv0 word", rx, 32'h0);
      full_frame(mk(2'b00, 4'd3, 16'h0), 32, "conv1", rx);
      chk("conv1 word", rx, 32'h0);
      full_frame(mk(2'b00, 4'd3, 16'h0), 32, "conv2", rx);
      chk("conv2 word", rx, 32'h3000_0000);
      chk("conv count", {16'h0, frame_count}, 32'd3);

      // WRITE / READ of register 2
      full_frame(mk(2'b10, 4'd2, 16'hBEEF), 32, "wr2", rx);
      full_frame(mk(2'b11, 4'd2, 16'h0000), 32, "rd2", rx);
      full_frame(mk(2'b00, 4'd1, 16'h0000), 32, "wr2 drain a", rx);
      chk("write echo", rx, 32'h0000_BEEF);
      full_frame(mk(2'b00, 4'd1, 16'h0000), 32, "wr2 drain b", rx);
      chk("read back", rx, 32'h0000_BEEF);

      // ID register is read-only
      full_frame(mk(2'b10, 4'd7, 16'h1234), 32, "wr7", rx);
      full_frame(mk(2'b11, 4'd7, 16'h0000), 32, "rd7", rx);
      full_frame(mk(2'b00, 4'd0, 16'h0000), 32, "rd7 drain a", rx);
      full_frame(mk(2'b00, 4'd0, 16'h0000), 32, "rd7 drain b", rx);
      chk("id read", rx, 32'h0000_2116);

      // Aborted WRITE after 20 bits changes nothing
      abort_frame(mk(2'b10, 4'd5, 16'hA5A5), 20, "abort wr5");
      full_frame(mk(2'b11, 4'd5, 16'h0000), 32, "rd5 after abort", rx);
      full_frame(mk(2'b00, 4'd2, 16'h0000), 32, "abort drain a", rx);
      full_frame(mk(2'b00, 4'd2, 16'h0000), 32, "abort drain b", rx);
      chk("reg5 untouched", rx, 32'h0);

      // Extra edges beyond 32 do not start a second frame
      full_frame(mk(2'b10, 4'd4, 16'h5A5A), 40, "long frame", rx);

      // Randomized traffic
      for (int k = 0; k < 60; k++) begin
         c   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            nb = $urandom_range(1, 31);
            abort_frame(c, nb, "rand abort");
         end else begin
            nb = (sel == 1) ? $urandom_range(33, 40) : 32;
            full_frame(c, nb, "rand", rx);
         end
      end

      // sample counter wrap, then CLEAR
      force dut.sample_cnt_q = 28'hFFF_FFFF;
      #1;
      release dut.sample_cnt_q;
      #1;
      m_scnt = 28'hFFF_FFFF;
      full_frame(mk(2'b00, 4'd5, 16'h0), 32, "wrap conv a", rx);
      full_frame(mk(2'b00, 4'd5, 16'h0), 32, "wrap conv b", rx);
      full_frame(mk(2'b01, 4'd0, 16'h0), 32, "clear", rx);
      chk("pre-wrap", rx, 32'h5FFF_FFFF);
      full_frame(mk(2'b00, 4'd0, 16'h0), 32, "conv after clear", rx);
      chk("post-wrap", rx, 32'h5000_0000);
      full_frame(mk(2'b00, 4'd0, 16'h0), 32, "clear drain a", rx);
      chk("clear resp", rx, 32'h0);
      full_frame(mk(2'b00, 4'd0, 16'h0), 32, "clear drain b", rx);
      chk("conv after clear resp", rx, 32'h0);

      // Five frames, then reset in the middle of a sixth
      for (int k = 0; k < 5; k++) full_frame(mk(2'b00, 4'd9, 16'h0), 32, "pre-reset", rx);
      cs_n = 1'b0;
      #5;
      for (int i = 0; i < 12; i++) begin
         sclk = 1'b1;
         mosi = 1'($urandom & 1);
         #5;
         sclk = 1'b0;
         #5;
      end
      rst_n = 1'b0;
      #3;
      model_reset();
      chk("midreset frame_count", {16'h0, frame_count}, 32'h0);
      chk("midreset last_cmd", last_cmd, 32'h0);
      cs_n = 1'b1;
      #3;
      rst_n = 1'b1;
      #5;
      full_frame(mk(2'b00, 4'd6, 16'h0), 32, "post-reset a", rx);
      chk("post-reset a word", rx, 32'h0);
      full_frame(mk(2'b00, 4'd6, 16'h0), 32, "post-reset b", rx);
      chk("post-reset b word", rx, 32'h0);
      full_frame(mk(2'b00, 4'd6, 16'h0), 32, "post-reset c", rx);
      chk("post-reset c word", rx, 32'h6000_0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
